dffasr_seq_ctrl: RTL and testbench

Sequencer that owns the asynchronous RSTB/SETB pins and the clock enable of a bank of async set/reset flops. It arbitrates set and reset requests, guarantees a minimum low pulse width on RSTB/SETB, and keeps the bank's clock gated across release so the recovery/removal windows can never be violated. It also never lets RSTB and SETB be low together. It sits between the block-level reset/preset requesters and the register bank's clock gate.

---
 rtl/dffasr_seq_ctrl.sv | 118 +++++++++++
 tb/tb_dffasr_seq_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/dffasr_seq_ctrl.sv
// Sequencer for the async RSTB/SETB pins and clock enable of a set/reset flop bank.
// Holds each strobe low for PULSE_CYC cycles and gates the clock for RECOV_CYC cycles after release.
module dffasr_seq_ctrl #(
    parameter int PULSE_CYC = 2,
    parameter int RECOV_CYC = 2
) (
    input  logic CLK,
    input  logic RST,
    input  logic RST_REQ,
    input  logic SET_REQ,
    output logic RSTB,
    output logic SETB,
    output logic CLK_EN,
    output logic BUSY,
    output logic ACK_R,
    output logic ACK_S
);
    localparam int MAXC = (PULSE_CYC > RECOV_CYC) ? PULSE_CYC : RECOV_CYC;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] PULSE_L = CW'(PULSE_CYC);
    localparam logic [CW-1:0] RECOV_L = CW'(RECOV_CYC);
    localparam logic [CW-1:0] ONE     = CW'(1);

    typedef enum logic [1:0] {IDLE, ASSERT, RECOVER, DONE} state_t;

    state_t        state, state_n;
    logic          kind, kind_n;        // 0 = clear, 1 = preset
    logic          req_seq, req_seq_n;  // sequence was asked for, so it earns an ACK
    logic          pend_r, pend_r_n;
    logic          pend_s, pend_s_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          rstb_n, setb_n, clk_en_n, busy_n, ack_r_n, ack_s_n;
    logic          same_r, same_s;

    always_comb begin
        state_n   = state;
        kind_n    = kind;
        req_seq_n = req_seq;
        cnt_n     = cnt;
        // A request matching the strobe already low is folded into it.
        same_r    = (state == ASSERT) && !kind;
        same_s    = (state == ASSERT) && kind;
        pend_r_n  = pend_r | (RST_REQ & ~same_r);
        pend_s_n  = pend_s | (SET_REQ & ~same_s);
        if ((same_r && RST_REQ) || (same_s && SET_REQ))
            req_seq_n = 1'b1;

        case (state)
            IDLE, DONE: begin
                if (pend_r_n || pend_s_n) begin
                    state_n   = ASSERT;
                    cnt_n     = PULSE_L;
                    req_seq_n = 1'b1;
                    if (pend_r_n) begin
                        kind_n   = 1'b0;
                        pend_r_n = 1'b0;
                    end else begin
                        kind_n   = 1'b1;
                        pend_s_n = 1'b0;
                    end
                end else begin
                    state_n = IDLE;
                end
            end
            ASSERT: begin
                if (cnt == ONE) begin
                    state_n = RECOVER;
                    cnt_n   = RECOV_L;
                end else begin
                    cnt_n = cnt - ONE;
                end
            end
            RECOVER: begin
                if (cnt == ONE) state_n = DONE;
                else            cnt_n   = cnt - ONE;
            end
            default: state_n = IDLE;
        endcase

        rstb_n   = !((state_n == ASSERT) && !kind_n);
        setb_n   = !((state_n == ASSERT) && kind_n);
        clk_en_n = (state_n == IDLE) || (state_n == DONE);
        busy_n   = (state_n == ASSERT) || (state_n == RECOVER);
        ack_r_n  = (state_n == DONE) && req_seq_n && !kind_n;
        ack_s_n  = (state_n == DONE) && req_seq_n && kind_n;
    end

    // Reset lands directly in a clear pulse so the bank is cleared at power-on.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= ASSERT;
            kind    <= 1'b0;
            req_seq <= 1'b0;
            cnt     <= PULSE_L;
            pend_r  <= 1'b0;
            pend_s  <= 1'b0;
            RSTB    <= 1'b0;
            SETB    <= 1'b1;
            CLK_EN  <= 1'b0;
            BUSY    <= 1'b1;
            ACK_R   <= 1'b0;
            ACK_S   <= 1'b0;
        end else begin
            state   <= state_n;
            kind    <= kind_n;
            req_seq <= req_seq_n;
            cnt     <= cnt_n;
            pend_r  <= pend_r_n;
            pend_s  <= pend_s_n;
            RSTB    <= rstb_n;
            SETB    <= setb_n;
            CLK_EN  <= clk_en_n;
            BUSY    <= busy_n;
            ACK_R   <= ack_r_n;
            ACK_S   <= ack_s_n;
        end
    end
endmodule

// File: tb/tb_dffasr_seq_ctrl.sv
// Directed bench for dffasr_seq_ctrl with PULSE_CYC=2, RECOV_CYC=3.
// Observed vector order: {RSTB, SETB, CLK_EN, BUSY, ACK_R, ACK_S}.
module tb_dffasr_seq_ctrl;
    localparam int PULSE = 2;
    localparam int RECOV = 3;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    logic RST_REQ = 1'b0;
    logic SET_REQ = 1'b0;
    logic RSTB, SETB, CLK_EN, BUSY, ACK_R, ACK_S;
    int   checks = 0;
    int   errors = 0;

    wire [5:0] obs = {RSTB, SETB, CLK_EN, BUSY, ACK_R, ACK_S};

    localparam logic [5:0] IDL = 6'b111000;
    localparam logic [5:0] A_R = 6'b010100;
    localparam logic [5:0] A_S = 6'b100100;
    localparam logic [5:0] REC = 6'b110100;
    localparam logic [5:0] D_R = 6'b111010;
    localparam logic [5:0] D_S = 6'b111001;

    dffasr_seq_ctrl #(.PULSE_CYC(PULSE), .RECOV_CYC(RECOV)) dut (
        .CLK(CLK), .RST(RST), .RST_REQ(RST_REQ), .SET_REQ(SET_REQ),
        .RSTB(RSTB), .SETB(SETB), .CLK_EN(CLK_EN), .BUSY(BUSY),
        .ACK_R(ACK_R), .ACK_S(ACK_S)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        logic [5:0] e [0:5];
        e = '{A_R, REC, REC, REC, IDL, IDL};
        RST = 1'b1;
        #1;
        checks++;
        if (obs !== A_R) begin
            errors++;
            $display("FAIL reset_async: got %b want %b", obs, A_R);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (obs !== A_R) begin
                errors++;
                $display("FAIL reset_hold[%0d]: got %b want %b", i, obs, A_R);
            end
        end
        RST = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (obs !== e[i]) begin
                errors++;
                $display("FAIL reset_release[%0d]: got %b want %b", i, obs, e[i]);
            end
        end
    endtask

    task automatic test_set();
        logic [5:0] e [0:6];
        e = '{A_S, A_S, REC, REC, REC, D_S, IDL};
        for (int i = 0; i < 7; i++) begin
            SET_REQ = (i == 0);
            tick();
            checks++;
            if (obs !== e[i]) begin
                errors++;
                $display("FAIL set_single[t+%0d]: got %b want %b", i, obs, e[i]);
            end
        end
        SET_REQ = 1'b0;
    endtask

    // both_mode 0: simultaneous requests; 1: coalesced clear plus a set during RECOVER
    task automatic test_both(input int mode);
        logic [5:0] e [0:12];
        e = '{A_R, A_R, REC, REC, REC, D_R, A_S, A_S, REC, REC, REC, D_S, IDL};
        for (int i = 0; i < 13; i++) begin
            if (mode == 0) begin
                RST_REQ = (i == 0);
                SET_REQ = (i == 0);
            end else begin
                RST_REQ = (i == 0) || (i == 1);
                SET_REQ = (i == 3);
            end
            tick();
            checks++;
            if (obs !== e[i]) begin
                errors++;
                $display("FAIL %s[t+%0d]: got %b want %b",
                         (mode == 0) ? "both_req" : "coalesce", i, obs, e[i]);
            end
        end
        RST_REQ = 1'b0;
        SET_REQ = 1'b0;
    endtask

    task automatic test_abort();
        logic [5:0] e [0:6];
        e = '{A_R, REC, REC, REC, IDL, IDL, IDL};
        SET_REQ = 1'b1;
        tick();
        SET_REQ = 1'b0;
        RST_REQ = 1'b1;        // opposite kind, left pending when RST hits
        tick();
        RST_REQ = 1'b0;
        checks++;
        if (obs !== A_S) begin
            errors++;
            $display("FAIL abort_pre: got %b want %b", obs, A_S);
        end
        RST = 1'b1;
        #1;
        checks++;
        if (obs !== A_R) begin
            errors++;
            $display("FAIL abort_async: got %b want %b", obs, A_R);
        end
        #1 RST = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick();
            checks++;
            if (obs !== e[i]) begin
                errors++;
                $display("FAIL abort_after[%0d]: got %b want %b", i, obs, e[i]);
            end
        end
    endtask

    task automatic test_random();
        int low_run = 0;
        int since_rel = 100;
        for (int c = 0; c < 3000; c++) begin
            RST_REQ = ($urandom_range(0, 7) == 0);
            SET_REQ = ($urandom_range(0, 7) == 0);
            tick();
            checks++;
            if (!RSTB && !SETB) begin
                errors++;
                $display("FAIL inv_both_low[%0d]: RSTB=%b SETB=%b want not both 0", c, RSTB, SETB);
            end
            if (!RSTB || !SETB) begin
                checks++;
                if (CLK_EN !== 1'b0) begin
                    errors++;
                    $display("FAIL inv_clken_strobe[%0d]: CLK_EN=%b want 0", c, CLK_EN);
                end
                low_run++;
                since_rel = 0;
            end else begin
                if (low_run > 0) begin
                    checks++;
                    if (low_run < PULSE) begin
                        errors++;
                        $display("FAIL inv_pulse_width[%0d]: low %0d want >= %0d", c, low_run, PULSE);
                    end
                end
                low_run = 0;
                since_rel++;
                if (since_rel <= RECOV) begin
                    checks++;
                    if (CLK_EN !== 1'b0) begin
                        errors++;
                        $display("FAIL inv_recovery[%0d]: CLK_EN=%b want 0 (%0d after release)",
                                 c, CLK_EN, since_rel);
                    end
                end
            end
        end
        RST_REQ = 1'b0;
        SET_REQ = 1'b0;
        repeat (20) tick();
        checks++;
        if (obs !== IDL) begin
            errors++;
            $display("FAIL random_drain: got %b want %b", obs, IDL);
        end
    endtask

    initial begin
        test_reset();
        test_set();
        test_both(0);
        test_both(1);
        test_abort();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
